mem_read_arbiter: RTL and testbench

- Shares the single graph-memory read port among NUM_CLIENTS requesters: edge cache, distance store, visited-set store.
- Replaces per-client tri-stating of mem_addr / mem_read_enable with one registered, always-driven port.
- Round-robin fairness, one outstanding read at a time; sits between the clients and the memory model at the top level.

---
 rtl/mem_read_arbiter_pkg.sv | 22 ++
 rtl/mem_read_arbiter_rr_priority_picker.sv | 34 +++
 rtl/mem_read_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_read_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Shared constants for the graph-memory read arbiter: default widths,
// client count, timeout limit, FSM encodings and the pointer-width helper.
package mem_read_arbiter_pkg;

    localparam int DEFAULT_NUM_MEM_CLIENTS = 3;
    localparam int DEFAULT_MADDR_WIDTH     = 16;
    localparam int DEFAULT_MDATA_WIDTH     = 16;
    localparam int DEFAULT_MEM_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        MEMARB_IDLE    = 2'd0,
        MEMARB_ISSUE   = 2'd1,
        MEMARB_WAIT    = 2'd2,
        MEMARB_RESPOND = 2'd3
    } memarb_state_t;

    // Width of a client index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_priority_picker.sv
// Round-robin priority picker: returns the first requesting client at or
// after rr_ptr, wrapping past the last client back to client 0.
module rr_priority_picker
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = DEFAULT_NUM_MEM_CLIENTS,
    parameter int PTR_W       = ptr_width(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [PTR_W-1:0]       grant,
    output logic                   any_req
);

    // Two descending scans: the wrapped-around side (below rr_ptr) first, then
    // the side at/after rr_ptr, so the lowest index at/after rr_ptr wins last.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req[i] && (i < int'(rr_ptr))) begin
                grant   = PTR_W'(i);
                any_req = 1'b1;
            end
        end
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(rr_ptr))) begin
                grant   = PTR_W'(i);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing the single graph-memory read port among
// NUM_CLIENTS requesters, one outstanding read at a time. Every output is a
// register; nothing is tri-stated.
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles; on expiry the client gets all-ones data and the
// sticky timeout_flag is raised.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS    = DEFAULT_NUM_MEM_CLIENTS,
    parameter int MADDR_WIDTH    = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = DEFAULT_MDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_MEM_TIMEOUT
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CLIENTS-1:0]             client_read_enable,
    input  logic [NUM_CLIENTS*MADDR_WIDTH-1:0] client_addr,
    output logic [NUM_CLIENTS-1:0]             client_ready,
    output logic [MDATA_WIDTH-1:0]             client_data,
    output logic [MADDR_WIDTH-1:0]             mem_addr,
    output logic                               mem_read_enable,
    input  logic [MDATA_WIDTH-1:0]             mem_data,
    input  logic                               mem_read_ready,
    output logic                               timeout_flag
);

    localparam int PTR_W = ptr_width(NUM_CLIENTS);

    memarb_state_t          state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant_q;
    logic [PTR_W-1:0]       pick;
    logic                   any_req;
    logic [MADDR_WIDTH-1:0] addr_sel;
    logic [NUM_CLIENTS-1:0] grant_onehot;
    logic [PTR_W-1:0]       rr_next;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] wait_cnt;
    logic            timeout_q;
`endif

    rr_priority_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .PTR_W       (PTR_W)
    ) u_picker (
        .req     (client_read_enable),
        .rr_ptr  (rr_ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    assign addr_sel     = client_addr[int'(pick)*MADDR_WIDTH +: MADDR_WIDTH];
    assign grant_onehot = NUM_CLIENTS'(1) << grant_q;
    // Explicit wrap so non-power-of-two client counts never reach an unused index.
    assign rr_next      = (int'(grant_q) == NUM_CLIENTS - 1) ? '0 : grant_q + PTR_W'(1);

    // Arbitration FSM; all port outputs are driven from these registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= MEMARB_IDLE;
            rr_ptr          <= '0;
            grant_q         <= '0;
            client_ready    <= '0;
            client_data     <= '0;
            mem_addr        <= '0;
            mem_read_enable <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt        <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below.
            client_ready    <= '0;
            mem_read_enable <= 1'b0;
            case (state)
                MEMARB_IDLE: begin
                    if (any_req) begin
                        grant_q         <= pick;
                        mem_addr        <= addr_sel;
                        mem_read_enable <= 1'b1;
                        state           <= MEMARB_ISSUE;
                    end
                end
                MEMARB_ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= MEMARB_WAIT;
                end
                MEMARB_WAIT: begin
                    if (mem_read_ready) begin
                        client_data  <= mem_data;
                        client_ready <= grant_onehot;
                        state        <= MEMARB_RESPOND;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        client_data  <= '1;
                        client_ready <= grant_onehot;
                        timeout_q    <= 1'b1;
                        state        <= MEMARB_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                MEMARB_RESPOND: begin
                    rr_ptr <= rr_next;
                    state  <= MEMARB_IDLE;
                end
                default: state <= MEMARB_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: reset values, single-read latency,
// round-robin order, blocking during a long read, reset mid-read, spurious
// responses, and WAIT behaviour with and without MEM_ARB_TIMEOUT_EN.
module tb_mem_read_arbiter;

    localparam int NC = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [NC-1:0]     client_read_enable;
    logic [NC*AW-1:0]  client_addr;
    logic [NC-1:0]     client_ready;
    logic [DW-1:0]     client_data;
    logic [AW-1:0]     mem_addr;
    logic              mem_read_enable;
    logic [DW-1:0]     mem_data;
    logic              mem_read_ready;
    logic              timeout_flag;

    int n_cmp = 0;
    int n_err = 0;

    mem_read_arbiter #(
        .NUM_CLIENTS    (NC),
        .MADDR_WIDTH    (AW),
        .MDATA_WIDTH    (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .client_read_enable (client_read_enable),
        .client_addr        (client_addr),
        .client_ready       (client_ready),
        .client_data        (client_data),
        .mem_addr           (mem_addr),
        .mem_read_enable    (mem_read_enable),
        .mem_data           (mem_data),
        .mem_read_ready     (mem_read_ready),
        .timeout_flag       (timeout_flag)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Wait (bounded) for the read strobe; returns in the ISSUE cycle.
    task automatic wait_strobe(input string tag, input logic [AW-1:0] exp_addr, output int n);
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (mem_read_enable) break;
        end
        check_eq({tag, "_strobe"}, 32'(mem_read_enable), 32'd1);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    endtask

    // Called in the first WAIT cycle: hold off `delay` cycles, then answer.
    task automatic respond(input string tag, input int delay, input logic [DW-1:0] data,
                           input logic [AW-1:0] exp_addr, input logic [NC-1:0] exp_ready);
        check_eq({tag, "_strobe_1cyc"}, 32'(mem_read_enable), 32'd0);
        for (int i = 0; i < delay; i++) begin
            check_eq({tag, "_wait_ready"}, 32'(client_ready), 32'd0);
            check_eq({tag, "_wait_strobe"}, 32'(mem_read_enable), 32'd0);
            tick();
        end
        check_eq({tag, "_addr_hold"}, 32'(mem_addr), 32'(exp_addr));
        mem_read_ready = 1'b1;
        mem_data       = data;
        tick();
        mem_read_ready = 1'b0;
        mem_data       = '0;
        check_eq({tag, "_ready"}, 32'(client_ready), 32'(exp_ready));
        check_eq({tag, "_data"}, 32'(client_data), 32'(data));
    endtask

    task automatic check_idle_outputs(input string tag, input logic [DW-1:0] exp_data);
        check_eq({tag, "_ready"}, 32'(client_ready), 32'd0);
        check_eq({tag, "_data"}, 32'(client_data), 32'(exp_data));
        check_eq({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_mren"}, 32'(mem_read_enable), 32'd0);
        check_eq({tag, "_tflag"}, 32'(timeout_flag), 32'd0);
    endtask

    initial begin
        int n;
        logic [NC-1:0]   rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [AW-1:0]   rr_adr [6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0200, 16'h0300};

        reset              = 1'b1;
        client_read_enable = '0;
        client_addr        = '0;
        mem_data           = '0;
        mem_read_ready     = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset", 16'h0000);

        // Round robin from rr_ptr=0 with all clients requesting continuously.
        client_addr[0*AW +: AW] = 16'h0100;
        client_addr[1*AW +: AW] = 16'h0200;
        client_addr[2*AW +: AW] = 16'h0300;
        client_read_enable      = 3'b111;
        reset                   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_strobe("rr", rr_adr[k], n);
            if (k > 0) check_eq("rr_gap", 32'(n), 32'd2);
            tick();
            respond("rr", 0, 16'(16'h1111 * (k + 1)), rr_adr[k], rr_exp[k]);
        end
        client_read_enable = '0;
        tick();
        check_eq("rr_pulse_1cyc", 32'(client_ready), 32'd0);

        // Single request, client 1 at 0x40, answered one cycle after the strobe.
        client_addr[1*AW +: AW] = 16'h0040;
        client_read_enable      = 3'b010;
        wait_strobe("single", 16'h0040, n);
        check_eq("single_latency", 32'(n), 32'd1);
        tick();
        respond("single", 0, 16'hBEEF, 16'h0040, 3'b010);
        client_read_enable = '0;

        // Client 2 with a 10-cycle memory delay; client 0 arrives meanwhile.
        client_addr[0*AW +: AW] = 16'h0011;
        client_addr[2*AW +: AW] = 16'h0033;
        client_read_enable      = 3'b100;
        wait_strobe("slow", 16'h0033, n);
        client_read_enable = 3'b101;
        tick();
        respond("slow", 10, 16'h5A5A, 16'h0033, 3'b100);
        client_read_enable = 3'b001;
        wait_strobe("after_slow", 16'h0011, n);
        tick();
        respond("after_slow", 0, 16'hC0DE, 16'h0011, 3'b001);
        client_read_enable = '0;

        // Reset in WAIT, memory answering the following cycle.
        client_addr[1*AW +: AW] = 16'h0055;
        client_read_enable      = 3'b010;
        wait_strobe("rstwait", 16'h0055, n);
        tick();
        reset = 1'b1;
        tick();
        reset              = 1'b0;
        client_read_enable = '0;
        mem_read_ready     = 1'b1;
        mem_data           = 16'h9999;
        check_idle_outputs("rstwait_out", 16'h0000);
        tick();
        check_idle_outputs("rstwait_late", 16'h0000);
        mem_read_ready     = 1'b0;
        mem_data           = '0;
        client_read_enable = 3'b101;
        wait_strobe("post_rst", 16'h0011, n);
        tick();
        respond("post_rst", 0, 16'h7777, 16'h0011, 3'b001);
        client_read_enable = '0;

        // Spurious responses in IDLE and in ISSUE.
        mem_read_ready = 1'b1;
        mem_data       = 16'hDEAD;
        tick();
        check_eq("spur_idle_ready", 32'(client_ready), 32'd0);
        check_eq("spur_idle_data", 32'(client_data), 32'h7777);
        tick();
        check_eq("spur_idle_data2", 32'(client_data), 32'h7777);
        mem_read_ready     = 1'b0;
        client_read_enable = 3'b100;
        wait_strobe("spur", 16'h0033, n);
        mem_read_ready = 1'b1;
        mem_data       = 16'hDEAD;
        tick();
        mem_read_ready = 1'b0;
        mem_data       = '0;
        check_eq("spur_issue_ready", 32'(client_ready), 32'd0);
        check_eq("spur_issue_data", 32'(client_data), 32'h7777);
        respond("spur", 1, 16'h2468, 16'h0033, 3'b100);
        client_read_enable = '0;

        // Memory that does not answer.
        client_addr[1*AW +: AW] = 16'h0066;
        client_read_enable      = 3'b010;
        wait_strobe("nomem", 16'h0066, n);
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check_eq("to_wait_ready", 32'(client_ready), 32'd0);
            check_eq("to_wait_flag", 32'(timeout_flag), 32'd0);
            tick();
        end
        check_eq("to_ready", 32'(client_ready), 32'b010);
        check_eq("to_data", 32'(client_data), 32'hFFFF);
        check_eq("to_flag", 32'(timeout_flag), 32'd1);
        client_read_enable = '0;
        tick();
        tick();
        check_eq("to_flag_sticky", 32'(timeout_flag), 32'd1);
        client_read_enable = 3'b001;
        wait_strobe("to_next", 16'h0011, n);
        tick();
        respond("to_next", 0, 16'h1357, 16'h0011, 3'b001);
        check_eq("to_flag_sticky2", 32'(timeout_flag), 32'd1);
        client_read_enable = '0;
`else
        for (int i = 0; i < 20; i++) begin
            check_eq("nomem_ready", 32'(client_ready), 32'd0);
            check_eq("nomem_flag", 32'(timeout_flag), 32'd0);
            tick();
        end
        respond("nomem", 0, 16'h4242, 16'h0066, 3'b010);
        client_read_enable = '0;
`endif

        // Final reset clears everything, including a sticky timeout.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("final_reset", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
